// File: rtl/twos_comp_to_sign_mag_serial_pkg.sv
// Shared definitions for the serial 2's complement -> sign/magnitude decoder:
// FSM state encodings and a constant-evaluable ceil(log2) helper.
package twos_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/twos_comp_to_sign_mag_serial_if.sv
// Handshake bundle for the serial decoder: an input word channel and a
// result channel, each a valid/ready pair.
interface twos_comp_to_sign_mag_serial_if #(
    parameter int WIDTH = 8
);
    // Both channels: a transfer happens on a rising clk edge where valid and
    // ready are both high; the producer keeps valid and data stable until then.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] twos_in;
    logic             out_valid;
    logic             out_ready;
    logic             sign_out;
    logic [WIDTH-1:0] mag_out;
    logic             min_neg;

    modport slave (
        input  in_valid, twos_in, out_ready,
        output in_ready, out_valid, sign_out, mag_out, min_neg
    );

    modport master (
        output in_valid, twos_in, out_ready,
        input  in_ready, out_valid, sign_out, mag_out, min_neg
    );
endinterface

// File: rtl/twos_comp_to_sign_mag_serial_bit_cell.sv
// One serial negation step: copy bits until the first 1 has gone by, then
// invert the rest when the word is negative.
module serial_twos_bit_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic x,
    input  logic sign,
    output logic b
);
    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clear) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | x;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    // The flag only reflects earlier bits, so the first 1 itself is copied.
    assign b = (sign & seen_one_q) ? ~x : x;
endmodule

// File: rtl/twos_comp_to_sign_mag_serial.sv
// Bit-serial 2's complement -> sign/magnitude decoder, LSB first, one bit per
// clock, with valid/ready handshakes on the word and result channels.
module twos_comp_to_sign_mag_serial
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    twos_comp_to_sign_mag_serial_if.slave         bus,
    output state_t                                dbg_state
);
    localparam int                 CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               min_neg_q, min_neg_d;
    logic               accept;
    logic               bit_en;
    logic               b;

    assign accept = (state_q == ST_IDLE) && bus.in_valid;
    assign bit_en = (state_q == ST_CONV);

    serial_twos_bit_cell u_bit_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (bit_en),
        .x     (shift_q[0]),
        .sign  (sign_q),
        .b     (b)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        min_neg_d = min_neg_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d   = bus.twos_in;
                    sign_d    = bus.twos_in[WIDTH-1];
                    cnt_d     = '0;
                    min_neg_d = 1'b0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d = shift_q >> 1;
                mag_d   = {b, mag_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Result flags are registered together with out_valid.
                    min_neg_d = sign_q && (mag_d == MIN_MAG);
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            min_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            min_neg_q <= min_neg_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sign_out  = sign_q;
    assign bus.mag_out   = mag_q;
    assign bus.min_neg   = min_neg_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_twos_comp_to_sign_mag_serial.sv
// Bench for the serial 2's complement -> sign/magnitude decoder (WIDTH=8):
// vector table, backpressure/reset sequences and a full 256-value sweep.
module tb_twos_comp_to_sign_mag_serial;
  import twos_comp_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             mn;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int outputs_seen = 0;
  int words_sent = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] exp_e;

  twos_comp_to_sign_mag_serial_if #(.WIDTH(WIDTH)) bus ();

  twos_comp_to_sign_mag_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // scoreboard: every completed result transfer pops one expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      outputs_seen++;
      check("result_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("result_sign_mn_mag", {bus.sign_out, bus.min_neg, bus.mag_out}, exp_e);
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_timeout", bus.in_ready, 1);
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic s, input logic [WIDTH-1:0] m,
                      input logic mn, input bit check_lat);
    int lat;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.twos_in  = w;
    @(posedge clk);
    exp_q.push_back({s, mn, m});
    words_sent++;
    #1;
    bus.in_valid = 1'b0;
    bus.twos_in  = WIDTH'($urandom);
    if (check_lat) begin
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", lat, WIDTH);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int   orig;
    logic s;
    logic [WIDTH-1:0] m8;
    logic [WIDTH-1:0] w;
    bit   rose;

    vecs[0] = '{8'd42, 1'b0, 8'd42, 1'b0};
    vecs[1] = '{8'hD6, 1'b1, 8'd42, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'd1,  1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 1'b0, 8'h7F, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 8'h7F, 1'b0};
    vecs[7] = '{8'h01, 1'b0, 8'h01, 1'b0};
    vecs[8] = '{8'hFE, 1'b1, 8'h02, 1'b0};

    bus.in_valid  = 1'b0;
    bus.twos_in   = '0;
    bus.out_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sign",      bus.sign_out,  0);
    check("rst_mag",       bus.mag_out,   0);
    check("rst_min_neg",   bus.min_neg,   0);
    check("rst_state",     dbg_state,     ST_IDLE);
    rst_n = 1'b1;

    // table of single words with latency check
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].din, vecs[i].sign, vecs[i].mag, vecs[i].mn, 1'b1);
    end

    // backpressure on -62
    wait_ready();
    bus.out_ready = 1'b0;
    send(8'hC2, 1'b1, 8'd62, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_mag",       bus.mag_out,   62);
      check("bp_sign",      bus.sign_out,  1);
      check("bp_in_ready",  bus.in_ready,  0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", bus.out_valid, 0);
    check("bp_release_in_ready",  bus.in_ready,  1);

    // reset in the middle of CONV for -79
    wait_ready();
    bus.in_valid = 1'b1;
    bus.twos_in  = 8'hB1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_conv", dbg_state, ST_CONV);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready",  bus.in_ready,  1);
    check("abort_mag",       bus.mag_out,   0);
    check("abort_sign",      bus.sign_out,  0);
    check("abort_min_neg",   bus.min_neg,   0);
    rst_n = 1'b1;
    rose = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) rose = 1'b1;
    end
    check("abort_no_out_valid", rose, 0);
    send(8'd37, 1'b0, 8'd37, 1'b0, 1'b1);

    // sweep: sign/magnitude source -> 2's complement -> DUT, in_valid held high
    for (int i = 0; i < 256; i++) begin
      orig = i - 128;
      s    = (orig < 0);
      m8   = WIDTH'(s ? -orig : orig);
      w    = s ? (~m8 + 1'b1) : m8;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.twos_in  = w;
      @(posedge clk);
      exp_q.push_back({s, (orig == -128), m8});
      words_sent++;
      #1;
      bus.twos_in = WIDTH'($urandom);
    end
    bus.in_valid = 1'b0;

    // drain
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("output_count",      outputs_seen, words_sent);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
